// File: rtl/ofifo_pkg.sv
// Shared defaults and derived widths for the partial-sum output FIFO.
package ofifo_pkg;

  localparam int unsigned ColDef     = 8;
  localparam int unsigned PsumBwDef  = 16;
  localparam int unsigned DepthDef   = 64;
  localparam int unsigned AfullThDef = 4;

  // A count must hold 0..depth inclusive, hence one bit more than the pointer.
  function automatic int unsigned lvl_bw_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psum_fifo_col.sv
// One column of the output FIFO: storage, wrapping pointers, occupancy count.
module psum_fifo_col
  import ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = PsumBwDef,
  parameter int unsigned depth   = DepthDef,
  localparam int unsigned lvl_bw = lvl_bw_of(depth),
  localparam int unsigned ptr_bw = $clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] din,
  input  logic               push,
  input  logic               pop,
  output logic [psum_bw-1:0] dout,
  output logic [lvl_bw-1:0]  count,
  output logic               full,
  output logic               empty
);

  logic [psum_bw-1:0] mem_q [depth];
  logic [ptr_bw-1:0]  wr_ptr_q, rd_ptr_q;
  logic [lvl_bw-1:0]  count_q;
  logic               push_ok, pop_ok;

  assign full  = (count_q == lvl_bw'(depth));
  assign empty = (count_q == '0);

  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot, so a full column still takes the write.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_bw'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ptr_bw'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + lvl_bw'(1);
        2'b01:   count_q <= count_q - lvl_bw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/psum_ofifo.sv
// Row-aligned output FIFO: col independent column FIFOs popped together as full rows.
module psum_ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned col      = ColDef,
  parameter int unsigned psum_bw  = PsumBwDef,
  parameter int unsigned depth    = DepthDef,
  parameter int unsigned afull_th = AfullThDef,
  localparam int unsigned lvl_bw  = lvl_bw_of(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  input  logic                   err_clr,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_vld,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_afull,
  output logic [lvl_bw-1:0]      o_level,
  output logic                   o_ovf,
  output logic                   o_udf
);

  localparam logic [lvl_bw-1:0] AfullLvl = lvl_bw'(depth - afull_th);

  logic [col-1:0]         full_c, empty_c;
  logic [lvl_bw-1:0]      count_c [col];
  logic [psum_bw*col-1:0] row;
  logic                   pop, ovf_set, udf_set;

  logic [psum_bw*col-1:0] out_q;
  logic                   out_vld_q, ovf_q, udf_q;

  for (genvar i = 0; i < col; i++) begin : g_col
    psum_fifo_col #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_col (
      .clk  (clk),
      .reset(reset),
      .din  (in[i*psum_bw +: psum_bw]),
      .push (wr[i]),
      .pop  (pop),
      .dout (row[i*psum_bw +: psum_bw]),
      .count(count_c[i]),
      .full (full_c[i]),
      .empty(empty_c[i])
    );
  end

  // Status depends on registered counts only; a same-cycle write is not yet readable.
  always_comb begin
    o_level = count_c[0];
    o_afull = 1'b0;
    for (int unsigned i = 0; i < col; i++) begin
      if (count_c[i] < o_level)   o_level = count_c[i];
      if (count_c[i] >= AfullLvl) o_afull = 1'b1;
    end
  end

  assign o_valid = ~|empty_c;
  assign o_full  = |full_c;
  assign o_ready = !o_full;

  assign pop     = rd && o_valid;
  assign udf_set = rd && !o_valid;
  assign ovf_set = |(wr & full_c) && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      out_vld_q <= pop;
      if (pop) out_q <= row;
      // A fresh error wins over a coincident clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (err_clr) udf_q <= 1'b0;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 Parameter col, default 8: number of independent column FIFOs.
REQ-002 Parameter psum_bw, default 16: bits per column entry.
REQ-003 Parameter depth, default 64: entries per column; power of two, >= 4.
REQ-004 Parameter afull_th, default 4: almost-full threshold; 1 <= afull_th < depth.
REQ-005 Local constant lvl_bw = log2(depth)+1.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port in, input, psum_bw*col: column i data at bits [(i+1)*psum_bw-1 : i*psum_bw].
REQ-009 Port wr, input, col: per-column push strobe.
REQ-010 Port rd, input, 1: row-pop request.
REQ-011 Port err_clr, input, 1: clears sticky error flags.
REQ-012 Port out, output, psum_bw*col: registered popped row, same column packing as in.
REQ-013 Port out_vld, output, 1: out holds a newly popped row this cycle.
REQ-014 Port o_valid, output, 1: every column is non-empty, so a full row is available.
REQ-015 Port o_full, output, 1: at least one column is full.
REQ-016 Port o_ready, output, 1: equals !o_full.
REQ-017 Port o_afull, output, 1: at least one column count >= depth-afull_th.
REQ-018 Port o_level, output, lvl_bw: minimum count across columns, i.e. complete rows stored.
REQ-019 Port o_ovf, output, 1: sticky overflow flag.
REQ-020 Port o_udf, output, 1: sticky underflow flag.

Function
REQ-021 Each column SHALL keep its own write pointer, read pointer and count in 0..depth; pointers wrap modulo depth.
REQ-022 A write with wr[i]=1 and column i not full SHALL store in slice i and increment count i.
REQ-023 A write with wr[i]=1 and column i full, with no pop in the same cycle, SHALL be dropped, leave column i unchanged and set o_ovf.
REQ-024 A pop SHALL occur when rd=1 and o_valid=1; it removes one entry from every column in the same cycle.
REQ-025 rd=1 with o_valid=0 SHALL pop nothing and set o_udf.
REQ-026 On a pop at cycle N, out SHALL present the popped row and out_vld SHALL be 1 at cycle N+1; read latency is 1.
REQ-027 out SHALL hold its last value when no pop occurs; out_vld SHALL be 1 only in the cycle after a pop.
REQ-028 A pop and wr[i] in the same cycle on a full column i SHALL accept the write; count i is unchanged.
REQ-029 A write to an empty column SHALL NOT become readable in the same cycle; o_valid SHALL reflect it from the next cycle.
REQ-030 o_valid, o_full, o_ready, o_afull and o_level SHALL be combinational functions of the registered counts only, never of the current-cycle wr or rd.
REQ-031 Back-to-back pops every cycle SHALL be supported while o_valid stays 1.
REQ-032 err_clr=1 SHALL clear o_ovf and o_udf; a set condition in the same cycle takes priority over err_clr.

Reset
REQ-033 reset=1 SHALL zero all pointers and counts and SHALL set out=0, out_vld=0, o_ovf=0, o_udf=0. Storage arrays are not reset.
REQ-034 After reset: o_valid=0, o_full=0, o_ready=1, o_afull=0, o_level=0.
REQ-035 reset SHALL take priority over wr, rd and err_clr in the same cycle; pending data is discarded when reset is asserted mid-operation.

Structure
REQ-036 Defaults for col, psum_bw, depth and afull_th SHALL live in shared package ofifo_pkg, alongside the lvl_bw derivation.
REQ-037 A single column SHALL be sub-module psum_fifo_col (storage, pointers, count, full and empty), instantiated col times in a generate loop.
REQ-038 Min-count reduction, row-pop control, output register and error flags SHALL reside in psum_ofifo.

Verification
REQ-039 Reset, then write 0x0011..0x0088 to columns 0..7 with wr=0xFF, then rd=1 one cycle later -> out_vld=1 and out=0x0088_..._0011 one cycle after rd; o_level 1 -> 0.
REQ-040 Column-skew test: wr=0x01 for 3 cycles, then wr=0xFE for 1 cycle -> o_valid rises the cycle after the 0xFE write; o_level=1.
REQ-041 Fill all columns to 64 entries -> o_full=1, o_ready=0 and o_afull=1 (set from count 60); a 65th wr=0xFF is dropped and sets o_ovf; data order is intact on drain.
REQ-042 With all columns full, assert rd=1 and wr=0xFF together -> pop accepted, counts stay at 64, o_ovf stays 0; 200 mixed cycles exercise pointer wrap and a scoreboard matches.
REQ-043 rd=1 when empty -> no out_vld, o_udf=1; err_clr -> o_udf=0; err_clr coincident with a new underflow -> o_udf stays 1.
REQ-044 Assert reset after 10 writes -> next cycle o_level=0, o_valid=0, out=0, and no stale data is returned after refill.
